// File: rtl/tdc_pkg.sv
// Shared widths, entry layout and capture-FSM states for the TDC result sink.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdc_pkg;

  localparam int DATA_W    = 15;
  localparam int INT_W     = 5;
  localparam int MAX_BEATS = 4;
  localparam int ENTRY_W   = DATA_W + INT_W;

  // Beat count that marks a full bank; beats beyond this are dropped.
  localparam logic [2:0] MAX_CNT = 3'(MAX_BEATS);

  typedef struct packed {
    logic [INT_W-1:0]  intensity;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } cap_state_t;

endpackage

// File: rtl/tdc_frame_bank.sv
// One frame bank: MAX_BEATS entries plus count/error/peak/full state.
// Latency: writes and commit visible the cycle after; rd_dat is combinational.
// Backpressure: none here; the parent never writes a full bank.
// Ports: wr_en/wr_idx/wr_dat write one entry and update the running peak;
//   commit/commit_cnt/commit_err close the frame and mark the bank full;
//   clr releases the bank; rd_idx/rd_dat read an entry; full/cnt/err/peak status.
module tdc_frame_bank
  import tdc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [1:0]         wr_idx,
  input  logic [ENTRY_W-1:0] wr_dat,
  input  logic               commit,
  input  logic [2:0]         commit_cnt,
  input  logic               commit_err,
  input  logic               clr,
  input  logic [1:0]         rd_idx,
  output logic [ENTRY_W-1:0] rd_dat,
  output logic               full,
  output logic [2:0]         cnt,
  output logic               err,
  output logic [1:0]         peak
);

  entry_t           mem [MAX_BEATS];
  entry_t           wr_ent;
  logic [INT_W-1:0] peak_int;

  assign wr_ent = wr_dat;
  assign rd_dat = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_BEATS; i++) mem[i] <= '0;
      full     <= 1'b0;
      cnt      <= '0;
      err      <= 1'b0;
      peak     <= '0;
      peak_int <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_idx] <= wr_ent;
        // Entry 0 seeds the peak; strict '>' keeps the lowest index on ties.
        if (wr_idx == 2'd0 || wr_ent.intensity > peak_int) begin
          peak     <= wr_idx;
          peak_int <= wr_ent.intensity;
        end
      end
      if (commit) begin
        full <= 1'b1;
        cnt  <= commit_cnt;
        err  <= commit_err;
      end
      if (clr) begin
        full     <= 1'b0;
        cnt      <= '0;
        err      <= 1'b0;
        peak     <= '0;
        peak_int <= '0;
      end
    end
  end

endmodule

// File: rtl/tdc_result_sink.sv
// Assembles TDC beats into frames in a ping-pong pair of banks and exposes the oldest.
// Latency: frame status 1 cycle after the commit beat; rd_data 1 cycle after rd_addr.
// Backpressure: TDC_Oready (registered) drops once both banks are full, returns after frm_ack.
// Ports: TDC_O* beat stream in; frm_valid/cnt/err/peak + rd_addr/rd_data read side;
//   frm_ack releases the read bank; TDC_INT/irq_clr/irq interrupt path.
module tdc_result_sink
  import tdc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  TDC_Odata,
  input  logic [INT_W-1:0]   TDC_Oint,
  input  logic [1:0]         TDC_Onum,
  input  logic               TDC_Olast,
  input  logic               TDC_Ovalid,
  output logic               TDC_Oready,
  input  logic               TDC_INT,
  output logic               frm_valid,
  output logic [2:0]         frm_cnt,
  output logic               frm_err,
  output logic [1:0]         frm_peak,
  input  logic               frm_ack,
  input  logic [1:0]         rd_addr,
  output logic [ENTRY_W-1:0] rd_data,
  input  logic               irq_clr,
  output logic               irq
);

  cap_state_t   state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;       // beats stored in the current frame (saturates at 4)
  logic [1:0]   onum_q, onum_d;
  logic         ovf_q, ovf_d;
  logic         wr_bank_q, rd_bank_q;
  logic         int_d_q, int_flag_q;

  logic         accept, ack_ok;
  logic         wr_en, commit, commit_err;
  logic [1:0]   wr_idx;
  logic [2:0]   commit_cnt;
  logic [1:0]   full_nx;

  logic [ENTRY_W-1:0] rd_dat0, rd_dat1;
  logic               full0, full1, err0, err1;
  logic [2:0]         cnt0, cnt1;
  logic [1:0]         peak0, peak1;

  assign accept = TDC_Ovalid & TDC_Oready;
  assign ack_ok = frm_ack & frm_valid;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    onum_d     = onum_q;
    ovf_d      = ovf_q;
    wr_en      = 1'b0;
    wr_idx     = cnt_q[1:0];
    commit     = 1'b0;
    commit_cnt = cnt_q;
    commit_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_en  = 1'b1;
          wr_idx = 2'd0;
          onum_d = TDC_Onum;
          ovf_d  = 1'b0;
          cnt_d  = 3'd1;
          if (TDC_Olast) begin
            commit     = 1'b1;
            commit_cnt = 3'd1;
            commit_err = (TDC_Onum != 2'd0);
            cnt_d      = 3'd0;
          end else begin
            state_d = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (accept) begin
          if (cnt_q < MAX_CNT) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
          if (TDC_Olast) begin
            commit     = 1'b1;
            commit_cnt = cnt_d;
            commit_err = ovf_d | (cnt_d != ({1'b0, onum_q} + 3'd1));
            cnt_d      = 3'd0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Occupancy after this cycle's commit and ack; ready is the registered complement of "both full".
  assign full_nx[0] = (full0 | (commit & ~wr_bank_q)) & ~(ack_ok & ~rd_bank_q);
  assign full_nx[1] = (full1 | (commit &  wr_bank_q)) & ~(ack_ok &  rd_bank_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      onum_q     <= '0;
      ovf_q      <= 1'b0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      TDC_Oready <= 1'b1;
      int_d_q    <= 1'b0;
      int_flag_q <= 1'b0;
      rd_data    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      onum_q     <= onum_d;
      ovf_q      <= ovf_d;
      wr_bank_q  <= wr_bank_q ^ commit;
      rd_bank_q  <= rd_bank_q ^ ack_ok;
      TDC_Oready <= ~(&full_nx);
      int_d_q    <= TDC_INT;
      // Rising edge beats a simultaneous clear.
      if (TDC_INT & ~int_d_q) int_flag_q <= 1'b1;
      else if (irq_clr)       int_flag_q <= 1'b0;
      rd_data    <= rd_bank_q ? rd_dat1 : rd_dat0;
    end
  end

  tdc_frame_bank u_bank0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en & ~wr_bank_q),
    .wr_idx     (wr_idx),
    .wr_dat     ({TDC_Oint, TDC_Odata}),
    .commit     (commit & ~wr_bank_q),
    .commit_cnt (commit_cnt),
    .commit_err (commit_err),
    .clr        (ack_ok & ~rd_bank_q),
    .rd_idx     (rd_addr),
    .rd_dat     (rd_dat0),
    .full       (full0),
    .cnt        (cnt0),
    .err        (err0),
    .peak       (peak0)
  );

  tdc_frame_bank u_bank1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en & wr_bank_q),
    .wr_idx     (wr_idx),
    .wr_dat     ({TDC_Oint, TDC_Odata}),
    .commit     (commit & wr_bank_q),
    .commit_cnt (commit_cnt),
    .commit_err (commit_err),
    .clr        (ack_ok & rd_bank_q),
    .rd_idx     (rd_addr),
    .rd_dat     (rd_dat1),
    .full       (full1),
    .cnt        (cnt1),
    .err        (err1),
    .peak       (peak1)
  );

  // Status of a bank still being captured is hidden until it is committed.
  assign frm_valid = rd_bank_q ? full1 : full0;
  assign frm_cnt   = frm_valid ? (rd_bank_q ? cnt1  : cnt0)  : 3'd0;
  assign frm_err   = frm_valid & (rd_bank_q ? err1 : err0);
  assign frm_peak  = frm_valid ? (rd_bank_q ? peak1 : peak0) : 2'd0;
  assign irq       = frm_valid | int_flag_q;

endmodule

// File: tb/tb_tdc_result_sink.sv
module tb_tdc_result_sink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] TDC_Odata = '0;
  logic [4:0]  TDC_Oint = '0;
  logic [1:0]  TDC_Onum = '0;
  logic        TDC_Olast = 1'b0;
  logic        TDC_Ovalid = 1'b0;
  logic        TDC_Oready;
  logic        TDC_INT = 1'b0;
  logic        frm_valid;
  logic [2:0]  frm_cnt;
  logic        frm_err;
  logic [1:0]  frm_peak;
  logic        frm_ack = 1'b0;
  logic [1:0]  rd_addr = '0;
  logic [19:0] rd_data;
  logic        irq_clr = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #2 clk = ~clk;

  tdc_result_sink dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .TDC_Odata  (TDC_Odata),
    .TDC_Oint   (TDC_Oint),
    .TDC_Onum   (TDC_Onum),
    .TDC_Olast  (TDC_Olast),
    .TDC_Ovalid (TDC_Ovalid),
    .TDC_Oready (TDC_Oready),
    .TDC_INT    (TDC_INT),
    .frm_valid  (frm_valid),
    .frm_cnt    (frm_cnt),
    .frm_err    (frm_err),
    .frm_peak   (frm_peak),
    .frm_ack    (frm_ack),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .irq_clr    (irq_clr),
    .irq        (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until the DUT accepts it (bounded wait).
  task automatic beat(input int d, input int i, input int n, input logic l);
    int k;
    TDC_Odata  = 15'(d);
    TDC_Oint   = 5'(i);
    TDC_Onum   = 2'(n);
    TDC_Olast  = l;
    TDC_Ovalid = 1'b1;
    k = 0;
    while (!TDC_Oready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("beat_ready", 32'(TDC_Oready), 1);
    @(posedge clk); #1;
    TDC_Ovalid = 1'b0;
    TDC_Olast  = 1'b0;
  endtask

  task automatic ack();
    frm_ack = 1'b1;
    @(posedge clk); #1;
    frm_ack = 1'b0;
  endtask

  task automatic rd(input int a, output logic [19:0] q);
    rd_addr = 2'(a);
    @(posedge clk); #1;
    q = rd_data;
  endtask

  task automatic chk_frame(input string tag, input int c, input int e, input int p);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(frm_valid), 1);
    chk({tag, "_cnt"},   32'(frm_cnt),   32'(c));
    chk({tag, "_err"},   32'(frm_err),   32'(e));
    chk({tag, "_peak"},  32'(frm_peak),  32'(p));
  endtask

  initial begin
    logic [19:0] q;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(TDC_Oready), 1);
    chk("rst_valid", 32'(frm_valid), 0);
    chk("rst_cnt",   32'(frm_cnt), 0);
    chk("rst_err",   32'(frm_err), 0);
    chk("rst_peak",  32'(frm_peak), 0);
    chk("rst_rdata", 32'(rd_data), 0);
    chk("rst_irq",   32'(irq), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-beat frame, Onum=1
    beat(100, 1, 1, 1'b0);
    beat(200, 5, 1, 1'b1);
    chk_frame("a", 2, 0, 1);
    chk("a_irq", 32'(irq), 1);
    rd(1, q); chk("a_rd1", 32'(q), 164040);  // {5,200}
    rd(0, q); chk("a_rd0", 32'(q), 32868);   // {1,100}
    ack();
    @(negedge clk);
    chk("a_released", 32'(frm_valid), 0);

    // Back-to-back frames, no ack: B (1 beat) then C (2 beats) fill both banks
    beat(7, 3, 0, 1'b1);
    beat(10, 2, 1, 1'b0);
    beat(11, 4, 1, 1'b1);
    @(negedge clk);
    chk("bc_ready_low", 32'(TDC_Oready), 0);
    chk_frame("b", 1, 0, 0);
    // Frame D is offered but must be held off
    TDC_Odata = 15'd55; TDC_Oint = 5'd9; TDC_Onum = 2'd0; TDC_Olast = 1'b1; TDC_Ovalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("d_held_ready", 32'(TDC_Oready), 0);
    chk("d_held_cnt",   32'(frm_cnt), 1);
    ack();
    beat(55, 9, 0, 1'b1);
    chk_frame("c", 2, 0, 1);
    chk("cd_ready_low", 32'(TDC_Oready), 0);
    ack();
    chk_frame("d", 1, 0, 0);
    rd(0, q); chk("d_rd0", 32'(q), 294967);  // {9,55}
    ack();
    @(negedge clk);
    chk("d_ready_back", 32'(TDC_Oready), 1);

    // Short frame: Onum=3 but last on beat 2
    beat(1, 1, 3, 1'b0);
    beat(2, 2, 3, 1'b1);
    chk_frame("short", 2, 1, 1);
    ack();

    // Overflow: six beats, last on the sixth; beats 5-6 (higher intensity) dropped
    for (int b = 0; b < 6; b++) beat(21 + b, 1 + b, 3, (b == 5));
    chk_frame("ovf", 4, 1, 3);
    rd(3, q); chk("ovf_rd3", 32'(q), 131096);  // {4,24}
    ack();

    // Peak tie-break: intensities 9,11,11,7
    beat(1, 9, 3, 1'b0);
    beat(2, 11, 3, 1'b0);
    beat(3, 11, 3, 1'b0);
    beat(4, 7, 3, 1'b1);
    chk_frame("tie", 4, 0, 1);
    ack();

    // Ack with nothing valid is ignored
    ack();
    @(negedge clk);
    chk("idle_ack_valid", 32'(frm_valid), 0);
    beat(77, 3, 0, 1'b1);
    chk_frame("post_idle_ack", 1, 0, 0);
    rd(0, q); chk("post_idle_ack_rd0", 32'(q), 98381);  // {3,77}
    ack();

    // Commit and ack in the same cycle
    beat(40, 1, 0, 1'b1);
    @(negedge clk);
    TDC_Odata = 15'd41; TDC_Oint = 5'd2; TDC_Onum = 2'd0; TDC_Olast = 1'b1; TDC_Ovalid = 1'b1;
    frm_ack = 1'b1;
    @(posedge clk); #1;
    TDC_Ovalid = 1'b0; TDC_Olast = 1'b0; frm_ack = 1'b0;
    @(negedge clk);
    chk("same_cyc_ready", 32'(TDC_Oready), 1);
    chk_frame("same_cyc", 1, 0, 0);
    rd(0, q); chk("same_cyc_rd0", 32'(q), 65577);  // {2,41}
    ack();

    // Interrupt flag
    @(negedge clk);
    chk("irq_idle", 32'(irq), 0);
    TDC_INT = 1'b1;
    repeat (2) @(negedge clk);
    TDC_INT = 1'b0;
    repeat (2) @(negedge clk);
    chk("irq_sticky", 32'(irq), 1);
    irq_clr = 1'b1;
    @(posedge clk); #1;
    irq_clr = 1'b0;
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 0);
    TDC_INT = 1'b1; irq_clr = 1'b1;
    @(posedge clk); #1;
    irq_clr = 1'b0;
    @(negedge clk);
    chk("irq_set_wins", 32'(irq), 1);
    TDC_INT = 1'b0; irq_clr = 1'b1;
    @(posedge clk); #1;
    irq_clr = 1'b0;

    // Reset mid-frame with one bank full
    beat(5, 5, 0, 1'b1);
    rd(0, q);
    beat(6, 6, 2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(TDC_Oready), 1);
    chk("mid_rst_valid", 32'(frm_valid), 0);
    chk("mid_rst_cnt",   32'(frm_cnt), 0);
    chk("mid_rst_rdata", 32'(rd_data), 0);
    chk("mid_rst_irq",   32'(irq), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(300, 2, 1, 1'b0);
    beat(301, 1, 1, 1'b1);
    chk_frame("post_rst", 2, 0, 0);
    rd(1, q); chk("post_rst_rd1", 32'(q), 33069);  // {1,301}

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
